// File: rtl/instruction_fetch.sv
// Fetch stage: owns the fetch PC, reads instruction words over a req/ack bus and
// presents them on IR, with a one-entry skid buffer for decode stalls and branch flush.
`timescale 1ns/1ps
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_en,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR,
    output logic        ir_valid,
    output logic [31:0] ir_pc
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_next;
    logic [31:0] tgt_hold;
    logic        tgt_load;
    logic [31:0] br_addr;

    logic        ack_vld;
    logic        keep_word;
    logic        advance;
    logic        buf_vld;
    logic        buf_vld_next;
    logic [31:0] buf_word;
    logic [31:0] buf_pc;

    assign br_addr   = br_target & ~32'h0000_0003;
    assign imem_req  = (state != ST_IDLE);
    assign imem_addr = fetch_pc;

    // An ack only counts against our own request; data from an abandoned
    // request (FLUSH) or one cancelled by a same-cycle branch is dropped.
    assign ack_vld   = imem_ack && imem_req;
    assign keep_word = (state == ST_REQ) && ack_vld && !br_en;
    assign advance   = !ir_valid || !stall;

    // Occupancy of the skid buffer after this edge; the FSM only issues
    // a new request when this is clear, so the buffer can never overflow.
    always_comb begin
        buf_vld_next = 1'b0;
        if (br_en) begin
            buf_vld_next = 1'b0;
        end else if (advance) begin
            buf_vld_next = 1'b0;
        end else begin
            buf_vld_next = buf_vld || keep_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_REQ;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
        end
    end

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        tgt_load      = 1'b0;
        case (state)
            ST_REQ: begin
                if (ack_vld) begin
                    if (br_en) begin
                        fetch_pc_next = br_addr;
                    end else begin
                        fetch_pc_next = fetch_pc + 32'd4;
                        if (buf_vld_next) begin
                            state_next = ST_IDLE;
                        end
                    end
                end else if (br_en) begin
                    tgt_load   = 1'b1;
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Address stays put until the abandoned read completes.
                if (ack_vld) begin
                    state_next    = ST_REQ;
                    fetch_pc_next = br_en ? br_addr : tgt_hold;
                end else if (br_en) begin
                    tgt_load = 1'b1;
                end
            end
            ST_IDLE: begin
                if (br_en) begin
                    fetch_pc_next = br_addr;
                    state_next    = ST_REQ;
                end else if (!buf_vld_next) begin
                    state_next = ST_REQ;
                end
            end
            default: begin
                state_next = ST_REQ;
            end
        endcase
    end

    // Output stage: IR/ir_pc with the skid buffer behind it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_valid <= 1'b0;
            IR       <= NOP_WORD;
            ir_pc    <= RESET_PC;
            buf_vld  <= 1'b0;
        end else if (br_en) begin
            ir_valid <= 1'b0;
            IR       <= NOP_WORD;
            buf_vld  <= 1'b0;
        end else if (advance) begin
            if (buf_vld) begin
                IR       <= buf_word;
                ir_pc    <= buf_pc;
                ir_valid <= 1'b1;
                buf_vld  <= 1'b0;
            end else if (keep_word) begin
                IR       <= imem_rdata;
                ir_pc    <= fetch_pc;
                ir_valid <= 1'b1;
            end else begin
                IR       <= NOP_WORD;
                ir_valid <= 1'b0;
            end
        end else if (keep_word) begin
            buf_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tgt_load) begin
            tgt_hold <= br_addr;
        end
        if (keep_word && !advance && !buf_vld) begin
            buf_word <= imem_rdata;
            buf_pc   <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with exact cycle expectations,
// then randomized stalls/branches/wait states checked against a program-order model.
`timescale 1ns/1ps
module tb_instruction_fetch;

    localparam logic [31:0] NOP     = 32'hF000_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br_en = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] IR;
    logic        ir_valid;
    logic [31:0] ir_pc;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic [31:0] w_ir;
    logic        w_valid;
    logic [31:0] w_pc;

    int wait_states = 0;
    int rand_ws     = 0;
    bit rand_wait   = 1'b0;
    bit force_ack   = 1'b0;
    int wcnt;
    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory model: ack after a programmable number of wait states.
    assign imem_ack   = (imem_req && (wcnt >= (rand_wait ? rand_ws : wait_states))) || force_ack;
    assign imem_rdata = word_of(imem_addr);
    assign w_ack      = w_req;
    assign w_rdata    = word_of(w_addr);

    always @(posedge clk or negedge rst) begin
        if (!rst) wcnt <= 0;
        else if (!imem_req || imem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    always @(posedge clk) begin
        if (imem_req && imem_ack) rand_ws <= int'($urandom_range(0, 3));
    end

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .br_en(br_en), .br_target(br_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .IR(IR), .ir_valid(ir_valid), .ir_pc(ir_pc)
    );

    instruction_fetch #(.RESET_PC(WRAP_PC)) dut_w (
        .clk(clk), .rst(rst), .stall(1'b0), .br_en(1'b0), .br_target(32'h0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack),
        .imem_rdata(w_rdata), .IR(w_ir), .ir_valid(w_valid), .ir_pc(w_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        p_valid, p_stall, p_br, p_req, p_ack;
        logic [31:0] p_ir, p_pc, p_addr, p_tgt;
        logic [31:0] exp_pc;
        int          delivered;

        // Reset values, asserted asynchronously with no clock edge yet
        rst = 1'b0;
        #2;
        chk("rst_req",    imem_req,  1);
        chk("rst_addr",   imem_addr, 32'h0);
        chk("rst_ir",     IR,        NOP);
        chk("rst_valid",  ir_valid,  0);
        chk("rst_pc",     ir_pc,     32'h0);
        chk("rst_w_addr", w_addr,    WRAP_PC);
        chk("rst_w_pc",   w_pc,      WRAP_PC);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Zero-wait streaming, plus the wrap-around instance
        tick();
        chk("s0_ir", IR, word_of(32'h0));
        chk("s0_pc", ir_pc, 32'h0);
        chk("s0_valid", ir_valid, 1);
        chk("s0_addr", imem_addr, 32'h4);
        chk("w0_ir", w_ir, word_of(WRAP_PC));
        chk("w0_pc", w_pc, WRAP_PC);
        tick();
        chk("s1_ir", IR, word_of(32'h4));
        chk("s1_pc", ir_pc, 32'h4);
        chk("w1_pc", w_pc, 32'hFFFF_FFFC);
        chk("w1_addr", w_addr, 32'h0);
        tick();
        chk("s2_ir", IR, word_of(32'h8));
        chk("s2_pc", ir_pc, 32'h8);
        chk("w2_pc", w_pc, 32'h0);
        chk("w2_ir", w_ir, word_of(32'h0));

        // Stall five cycles while IR holds word@8
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_ir", IR, word_of(32'h8));
            chk("stall_pc", ir_pc, 32'h8);
            chk("stall_req", imem_req, 0);
        end
        stall = 1'b0;
        tick();
        chk("rel_ir", IR, word_of(32'hC));
        chk("rel_pc", ir_pc, 32'hC);
        chk("rel_req", imem_req, 1);
        chk("rel_addr", imem_addr, 32'h10);
        tick();
        chk("rel2_ir", IR, word_of(32'h10));
        chk("rel2_pc", ir_pc, 32'h10);

        // Branch to 0x100 while a 3-wait-state read of 0x20 is pending
        repeat (3) tick();
        chk("pre_br_addr", imem_addr, 32'h20);
        wait_states = 3;
        tick();
        chk("wait_valid", ir_valid, 0);
        br_en = 1'b1;
        br_target = 32'h0000_0103;
        tick();
        br_en = 1'b0;
        chk("flush_req", imem_req, 1);
        chk("flush_addr", imem_addr, 32'h20);
        chk("flush_valid", ir_valid, 0);
        tick();
        chk("flush_ack_ir", IR, NOP);
        tick();
        chk("tgt_addr", imem_addr, 32'h100);
        chk("tgt_req", imem_req, 1);
        chk("no_0x20_ir", IR, NOP);
        chk("no_0x20_valid", ir_valid, 0);
        wait_states = 0;
        tick();
        chk("tgt_ir", IR, word_of(32'h100));
        chk("tgt_pc", ir_pc, 32'h100);
        chk("tgt_valid", ir_valid, 1);

        // Branch with a stray ack while stalled and the buffer is full
        stall = 1'b1;
        tick();
        chk("full_req", imem_req, 0);
        chk("full_ir", IR, word_of(32'h100));
        br_en = 1'b1;
        br_target = 32'h0000_0200;
        force_ack = 1'b1;
        tick();
        br_en = 1'b0;
        force_ack = 1'b0;
        stall = 1'b0;
        chk("brfull_valid", ir_valid, 0);
        chk("brfull_ir", IR, NOP);
        chk("brfull_pc", ir_pc, 32'h100);
        chk("brfull_addr", imem_addr, 32'h200);
        chk("brfull_req", imem_req, 1);
        tick();
        chk("brfull_next_ir", IR, word_of(32'h200));
        chk("brfull_next_pc", ir_pc, 32'h200);

        // Reset with the buffer full and slow memory configured
        stall = 1'b1;
        tick();
        chk("pre_rst_req", imem_req, 0);
        wait_states = 3;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_req", imem_req, 1);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_ir", IR, NOP);
        chk("mid_rst_valid", ir_valid, 0);
        chk("mid_rst_pc", ir_pc, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_addr", imem_addr, 32'h0);
            chk("post_rst_valid", ir_valid, 0);
        end
        tick();
        chk("post_rst_ir", IR, word_of(32'h0));
        chk("post_rst_pc", ir_pc, 32'h0);
        chk("post_rst_next", imem_addr, 32'h4);

        // Randomized traffic against a program-order model
        wait_states = 0;
        rand_wait = 1'b1;
        rst = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
        exp_pc = 32'h0;
        delivered = 0;
        for (int c = 0; c < 1500; c++) begin
            stall     = ($urandom_range(0, 3) == 0);
            br_en     = ($urandom_range(0, 15) == 0);
            br_target = $urandom & 32'h0000_0FFF;
            p_valid = ir_valid;
            p_ir    = IR;
            p_pc    = ir_pc;
            p_req   = imem_req;
            p_ack   = imem_ack;
            p_addr  = imem_addr;
            p_stall = stall;
            p_br    = br_en;
            p_tgt   = br_target;
            tick();
            chk("r_align", {30'h0, imem_addr[1:0]}, 32'h0);
            if (p_req && !p_ack) begin
                chk("r_req_hold", imem_req, 1);
                chk("r_addr_hold", imem_addr, p_addr);
            end
            if (p_br) begin
                chk("r_br_valid", ir_valid, 0);
                chk("r_br_ir", IR, NOP);
                chk("r_br_pc", ir_pc, p_pc);
                exp_pc = {p_tgt[31:2], 2'b00};
            end else if (p_valid && p_stall) begin
                chk("r_hold_valid", ir_valid, 1);
                chk("r_hold_ir", IR, p_ir);
                chk("r_hold_pc", ir_pc, p_pc);
            end else if (ir_valid) begin
                chk("r_seq_pc", ir_pc, exp_pc);
                chk("r_seq_ir", IR, word_of(exp_pc));
                exp_pc = ir_pc + 32'd4;
                delivered++;
            end else begin
                chk("r_idle_ir", IR, NOP);
                chk("r_idle_pc", ir_pc, p_pc);
            end
        end
        br_en = 1'b0;
        stall = 1'b0;
        chk("r_progress", (delivered >= 100) ? 32'd1 : 32'd0, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
